// File: rtl/irq_wdt_if.sv
// irq_wdt_if: core-facing signal bundle of the interrupt/watchdog controller
interface irq_wdt_if #(parameter int WDT_W = 32);
  logic             ext_irq_i;
  logic             wdt_en_i;
  logic             wdt_kick_i;
  logic             wdt_load_we_i;
  logic [WDT_W-1:0] wdt_load_i;
  logic             MIE;
  logic             MEIE;
  logic             MTIE;
  logic             MRET;
  logic             WFI;
  logic             stall_wrap;
  logic             ir_sc_taken;
  logic             ir_wdt_taken;
  logic             in_handler_o;
  logic [1:0]       cause_o;
  logic             wdt_timeout_o;
  modport master (
    output ext_irq_i, wdt_en_i, wdt_kick_i, wdt_load_we_i, wdt_load_i,
    output MIE, MEIE, MTIE, MRET, WFI, stall_wrap,
    input  ir_sc_taken, ir_wdt_taken, in_handler_o, cause_o, wdt_timeout_o
  );
  modport slave (
    input  ext_irq_i, wdt_en_i, wdt_kick_i, wdt_load_we_i, wdt_load_i,
    input  MIE, MEIE, MTIE, MRET, WFI, stall_wrap,
    output ir_sc_taken, ir_wdt_taken, in_handler_o, cause_o, wdt_timeout_o
  );
endinterface

// File: rtl/irq_wdt_ctrl.sv
// irq_wdt_ctrl: machine interrupt controller with watchdog and trap-in-progress tracking
module irq_wdt_ctrl #(parameter int WDT_W = 32) (
  input  logic     clk,
  input  logic     rst,
  irq_wdt_if.slave bus
);
  typedef enum logic {IDLE, HANDLER} state_t;
  state_t           r_state, w_state_nxt;
  logic             r_ext_q, r_timeout, r_sc, r_wdt;
  logic [1:0]       r_cause, w_cause_nxt;
  logic [WDT_W-1:0] r_wdt_cnt, r_wdt_lim;
  logic             w_wdt_clr, w_at_lim, w_ext_pend, w_wdt_pend, w_elig, w_take, w_ret;
  logic             w_sc_nxt, w_wdt_nxt;
  assign w_wdt_clr  = bus.wdt_kick_i | !bus.wdt_en_i | bus.wdt_load_we_i;
  assign w_at_lim   = r_wdt_cnt == r_wdt_lim;
  assign w_ext_pend = r_ext_q & bus.MEIE;
  assign w_wdt_pend = r_timeout & bus.MTIE;
  // WFI wakes on an enabled external line even with MIE clear
  assign w_elig = (bus.MIE & (w_ext_pend | w_wdt_pend)) | (bus.WFI & w_ext_pend);
  assign w_take = (r_state == IDLE) & w_elig & !bus.stall_wrap;
  assign w_ret  = (r_state == HANDLER) & bus.MRET & !bus.stall_wrap;
  // line register, limit register and saturating watchdog counter
  always_ff @(posedge clk)
    if (rst) begin
      r_ext_q   <= 1'b0;
      r_wdt_lim <= '1;
      r_wdt_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_ext_q   <= bus.ext_irq_i;
      if (bus.wdt_load_we_i) r_wdt_lim <= bus.wdt_load_i;
      r_wdt_cnt <= w_wdt_clr ? '0 : w_at_lim ? r_wdt_cnt : r_wdt_cnt + WDT_W'(1);
      r_timeout <= !w_wdt_clr & (r_timeout | w_at_lim);
    end
  // state register, with the take pulses and cause registered alongside
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_sc    <= 1'b0;
      r_wdt   <= 1'b0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
      r_wdt   <= w_wdt_nxt;
      r_cause <= w_cause_nxt;
    end
  // next state: take moves to HANDLER, an unstalled MRET returns to IDLE
  always_comb
    w_state_nxt = w_take ? HANDLER : w_ret ? IDLE : r_state;
  // outputs: watchdog wins over external, only one pulse per take
  always_comb begin
    w_wdt_nxt   = w_take & bus.MIE & w_wdt_pend;
    w_sc_nxt    = w_take & !w_wdt_nxt;
    w_cause_nxt = w_take ? (w_wdt_nxt ? 2'b10 : 2'b01) : w_ret ? 2'b00 : r_cause;
  end
  assign bus.ir_sc_taken   = r_sc;
  assign bus.ir_wdt_taken  = r_wdt;
  assign bus.in_handler_o  = r_state == HANDLER;
  assign bus.cause_o       = r_cause;
  assign bus.wdt_timeout_o = r_timeout;
endmodule
